mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory between three requesters: instruction fetch, execute-stage load/store, and the register/memory display scanner that drives the show outputs.
- Sits between the control unit and the memory, in the memory clock domain.
- Grants one access at a time, sequences enable/write/latency, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port program/data memory between three requesters:
//   instruction fetch, execute-stage load/store, and the display scanner
//   (debug, read-only). One access is in flight at a time. Each access runs
//   IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
//
//   Handshake: a requester raises its level req together with stable
//   addr/we/wdata and holds them until the cycle in which its one-cycle ack
//   pulse is high. Only IDLE samples requests. A req still high in the IDLE
//   cycle after the ack is a new access.
//
//   Priority is data > fetch > debug. A debug request that has lost
//   STARVE_LIMIT arbitrations in a row wins the next one.
//
// Ports
//   i_CLK, i_RST            memory clock, asynchronous active-low reset
//   i_FETCH_*/o_FETCH_*     fetch request, address, ack pulse, held read data
//   i_DATA_*/o_DATA_*       load/store request, we, address, wdata, ack, held load data
//   i_DBG_*/o_DBG_*         scanner request, address, ack pulse, held read data
//   o_MEM_*/i_MEM_RDATA     memory enable, write enable, address, wdata, read data
//   o_BUSY                  high whenever the FSM is not in IDLE
//   o_OWNER                 current owner: 00 none, 01 fetch, 10 data, 11 debug
//
// Optional build macro
//   MEM_PORT_ARBITER_PERF_EN  adds o_FETCH_STALL, a saturating count of cycles
//                             with fetch requesting but not being acked.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_FETCH_REQ,
  input  logic [ADDR_W-1:0] i_FETCH_ADDR,
  output logic              o_FETCH_ACK,
  output logic [DATA_W-1:0] o_FETCH_DATA,
  input  logic              i_DATA_REQ,
  input  logic              i_DATA_WE,
  input  logic [ADDR_W-1:0] i_DATA_ADDR,
  input  logic [DATA_W-1:0] i_DATA_WDATA,
  output logic              o_DATA_ACK,
  output logic [DATA_W-1:0] o_DATA_RDATA,
  input  logic              i_DBG_REQ,
  input  logic [ADDR_W-1:0] i_DBG_ADDR,
  output logic              o_DBG_ACK,
  output logic [DATA_W-1:0] o_DBG_RDATA,
  output logic              o_MEM_EN,
  output logic              o_MEM_WE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [DATA_W-1:0] o_MEM_WDATA,
  input  logic [DATA_W-1:0] i_MEM_RDATA,
  output logic              o_BUSY,
  output logic [1:0]        o_OWNER
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0]       o_FETCH_STALL
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;
  localparam logic [1:0] OWN_DBG   = 2'b11;

  localparam logic [3:0] AGE_MAX  = 4'(STARVE_LIMIT);
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        grant;
  logic [1:0]        owner;
  logic [3:0]        age;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Winner among the live requests; only consumed while in IDLE.
  always_comb begin
    grant = OWN_NONE;
    if (i_DBG_REQ && (age == AGE_MAX)) grant = OWN_DBG;
    else if (i_DATA_REQ)               grant = OWN_DATA;
    else if (i_FETCH_REQ)              grant = OWN_FETCH;
    else if (i_DBG_REQ)                grant = OWN_DBG;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant != OWN_NONE) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == LAT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      owner        <= OWN_NONE;
      age          <= '0;
      lat_cnt      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          owner <= grant;
          case (grant)
            OWN_FETCH: begin
              addr_q  <= i_FETCH_ADDR;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            OWN_DATA: begin
              addr_q  <= i_DATA_ADDR;
              we_q    <= i_DATA_WE;
              wdata_q <= i_DATA_WDATA;
            end
            OWN_DBG: begin
              addr_q  <= i_DBG_ADDR;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            default: ;
          endcase
          // Age tracks consecutive lost arbitrations of a pending debug req.
          if (i_DBG_REQ) begin
            if (grant == OWN_DBG)    age <= '0;
            else if (age < AGE_MAX)  age <= age + 4'd1;
          end
        end
        S_ISSUE: lat_cnt <= '0;
        S_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT_LAST) begin
            case (owner)
              OWN_FETCH: fetch_data_q <= i_MEM_RDATA;
              OWN_DATA:  if (!we_q) data_rdata_q <= i_MEM_RDATA;
              OWN_DBG:   dbg_rdata_q <= i_MEM_RDATA;
              default: ;
            endcase
          end
        end
        S_DONE:  owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  assign o_MEM_EN     = (state == S_ISSUE);
  assign o_MEM_WE     = (state == S_ISSUE) && we_q;
  assign o_MEM_ADDR   = addr_q;
  assign o_MEM_WDATA  = wdata_q;
  assign o_FETCH_ACK  = (state == S_DONE) && (owner == OWN_FETCH);
  assign o_DATA_ACK   = (state == S_DONE) && (owner == OWN_DATA);
  assign o_DBG_ACK    = (state == S_DONE) && (owner == OWN_DBG);
  assign o_FETCH_DATA = fetch_data_q;
  assign o_DATA_RDATA = data_rdata_q;
  assign o_DBG_RDATA  = dbg_rdata_q;
  assign o_BUSY       = (state != S_IDLE);
  assign o_OWNER      = owner;

`ifdef MEM_PORT_ARBITER_PERF_EN
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_FETCH_STALL <= '0;
    end else if (i_FETCH_REQ && !o_FETCH_ACK && (o_FETCH_STALL != 16'hFFFF)) begin
      o_FETCH_STALL <= o_FETCH_STALL + 16'd1;
    end
  end
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int L  = 1;
  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_req, data_req, data_we, dbg_req;
  logic [7:0]  fetch_addr, data_addr, dbg_addr;
  logic [15:0] data_wdata;
  logic        fetch_ack, data_ack, dbg_ack;
  logic [15:0] fetch_data, data_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic [1:0]  owner;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] fetch_stall;
  logic [15:0] stall_at_ack;
`endif

  // ---------------- memory model ----------------
  function automatic logic [15:0] init_word(input logic [7:0] a);
    return {a ^ 8'h04, a};
  endfunction

  logic [15:0]  wmem [256];
  logic [255:0] wvalid = '0;
  logic [15:0]  mem_rdata = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= wvalid[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);
      end
    end
  end

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(L), .STARVE_LIMIT(SL)) dut (
    .i_CLK(clk), .i_RST(rst_n),
    .i_FETCH_REQ(fetch_req), .i_FETCH_ADDR(fetch_addr),
    .o_FETCH_ACK(fetch_ack), .o_FETCH_DATA(fetch_data),
    .i_DATA_REQ(data_req), .i_DATA_WE(data_we), .i_DATA_ADDR(data_addr),
    .i_DATA_WDATA(data_wdata), .o_DATA_ACK(data_ack), .o_DATA_RDATA(data_rdata),
    .i_DBG_REQ(dbg_req), .i_DBG_ADDR(dbg_addr),
    .o_DBG_ACK(dbg_ack), .o_DBG_RDATA(dbg_rdata),
    .o_MEM_EN(mem_en), .o_MEM_WE(mem_we), .o_MEM_ADDR(mem_addr),
    .o_MEM_WDATA(mem_wdata), .i_MEM_RDATA(mem_rdata),
    .o_BUSY(busy), .o_OWNER(owner)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .o_FETCH_STALL(fetch_stall)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  int hold [4];
  int ack_at [4];
  int ack_cnt [4];

  task automatic set_req(input int k, input logic v);
    case (k)
      1: fetch_req = v;
      2: data_req  = v;
      default: dbg_req = v;
    endcase
  endtask

  task automatic clear_inputs();
    fetch_req = 0; data_req = 0; dbg_req = 0; data_we = 0;
    fetch_addr = 0; data_addr = 0; dbg_addr = 0; data_wdata = 0;
  endtask

  // Called at a negedge; leaves rst_n high at a negedge, so the current
  // cycle is the first arbitration cycle.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs n cycles starting from the current negedge (cycle 0), recording
  // first ack cycle and ack count per requester. A requester drops its req
  // in its ack cycle unless it still has re-issues left in hold[k].
  task automatic run_window(input int n);
    logic a [4];
    for (int k = 0; k < 4; k++) begin ack_at[k] = -1; ack_cnt[k] = 0; end
    for (int c = 0; c < n; c++) begin
      a[1] = fetch_ack; a[2] = data_ack; a[3] = dbg_ack;
      for (int k = 1; k < 4; k++) begin
        if (a[k] === 1'b1) begin
          ack_cnt[k]++;
          if (ack_at[k] < 0) ack_at[k] = c;
          if (hold[k] > 0) hold[k]--;
          else set_req(k, 1'b0);
        end
      end
`ifdef MEM_PORT_ARBITER_PERF_EN
      if (fetch_ack === 1'b1) stall_at_ack = fetch_stall;
`endif
      @(negedge clk);
    end
  endtask

  // ---------------- random-phase reference model state ----------------
  int          act [4];
  logic [7:0]  r_addr [4];
  logic        r_we [4];
  logic [15:0] r_wdata [4];
  int          m_busy, m_owner, m_grant_c, m_ack_c, m_wr, m_age, w;
  logic [15:0] m_rd, e_fd, e_dd, e_gd;
  int          ack_exp, en_exp, own_exp;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    for (int k = 0; k < 4; k++) hold[k] = 0;
    clear_inputs();

    // ---- reset state ----
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_acks", {fetch_ack, data_ack, dbg_ack}, 0);
    chk("rst_data", {fetch_data, data_rdata, dbg_rdata}, 0);
    rst_n = 1'b1;

    // ---- single fetch ----
    fetch_req = 1; fetch_addr = 8'h05;                 // cycle 0
    chk("sf_c0_en", mem_en, 0);
    @(negedge clk);                                     // cycle 1
    chk("sf_c1_en", mem_en, 1);
    chk("sf_c1_addr", mem_addr, 8'h05);
    chk("sf_c1_we", mem_we, 0);
    chk("sf_c1_owner", owner, 2'b01);
    @(negedge clk);                                     // cycle 2
    chk("sf_c2_en", mem_en, 0);
    chk("sf_c2_owner", owner, 2'b01);
    chk("sf_c2_ack", fetch_ack, 0);
    @(negedge clk);                                     // cycle 3
    chk("sf_c3_ack", fetch_ack, 1);
    chk("sf_c3_data", fetch_data, 16'h0105);
    chk("sf_c3_owner", owner, 2'b01);
    fetch_req = 0;
    @(negedge clk);                                     // cycle 4
    chk("sf_c4_ack", fetch_ack, 0);
    chk("sf_c4_owner", owner, 0);
    chk("sf_c4_busy", busy, 0);
    chk("sf_c4_hold", fetch_data, 16'h0105);

    // ---- store then load ----
    data_req = 1; data_we = 1; data_addr = 8'h20; data_wdata = 16'hBEEF;
    ref_mem[8'h20] = 16'hBEEF;
    @(negedge clk);
    chk("st_en", mem_en, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 16'hBEEF);
    chk("st_addr", mem_addr, 8'h20);
    @(negedge clk);
    chk("st_wait_we", mem_we, 0);
    @(negedge clk);
    chk("st_ack", data_ack, 1);
    chk("st_rdata_kept", data_rdata, 0);
    data_req = 0;
    @(negedge clk);
    data_req = 1; data_we = 0;
    @(negedge clk);
    chk("ld_en", mem_en, 1);
    chk("ld_we", mem_we, 0);
    repeat (2) @(negedge clk);
    chk("ld_ack", data_ack, 1);
    chk("ld_rdata", data_rdata, 16'hBEEF);
    data_req = 0;
    @(negedge clk);

    // ---- collision: all three in the same IDLE cycle ----
    fetch_req = 1; fetch_addr = 8'h05;
    data_req = 1; data_we = 0; data_addr = 8'h20;
    dbg_req = 1; dbg_addr = 8'h33;
    run_window(13);
    chk("coll_data_at", ack_at[2], 3);
    chk("coll_fetch_at", ack_at[1], 7);
    chk("coll_dbg_at", ack_at[3], 11);
    chk("coll_dbg_data", dbg_rdata, 16'h3733);
    chk("coll_busy_end", busy, 0);

    // ---- starvation: data and fetch held, debug pending ----
    hold[1] = 100; hold[2] = 100;
    fetch_req = 1; data_req = 1; dbg_req = 1; dbg_addr = 8'h40;
    run_window(20);
    clear_inputs();
    hold[1] = 0; hold[2] = 0;
    chk("stv_dbg_at", ack_at[3], 19);
    chk("stv_data_cnt", ack_cnt[2], 4);
    chk("stv_fetch_cnt", ack_cnt[1], 0);
    chk("stv_dbg_data", dbg_rdata, 16'h4440);
    repeat (2) @(negedge clk);
    // age must be back to 0: data wins the next data+debug collision
    data_req = 1; data_addr = 8'h20; dbg_req = 1; dbg_addr = 8'h41;
    run_window(9);
    chk("age_clr_data_at", ack_at[2], 3);
    chk("age_clr_dbg_at", ack_at[3], 7);

    // ---- reset mid-access ----
    fetch_req = 1; fetch_addr = 8'h05;
    repeat (2) @(negedge clk);                          // cycle 2 = WAIT
    chk("rm_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    fetch_req = 0;
    #1;
    chk("rm_en", mem_en, 0);
    chk("rm_busy", busy, 0);
    chk("rm_owner", owner, 0);
    chk("rm_acks", {fetch_ack, data_ack, dbg_ack}, 0);
    chk("rm_data", {fetch_data, data_rdata, dbg_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_window(8);
    chk("rm_no_ack", ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 0);
    fetch_req = 1; fetch_addr = 8'h05;
    run_window(6);
    chk("rm_refetch_at", ack_at[1], 3);
    chk("rm_refetch_data", fetch_data, 16'h0105);

`ifdef MEM_PORT_ARBITER_PERF_EN
    // ---- fetch stall counter ----
    do_reset();
    hold[2] = 1;
    fetch_req = 1; fetch_addr = 8'h05;
    data_req = 1; data_we = 0; data_addr = 8'h20;
    run_window(13);
    chk("perf_fetch_at", ack_at[1], 11);
    chk("perf_stall", stall_at_ack, 11);
`endif

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    for (int k = 0; k < 4; k++) act[k] = 0;
    m_busy = 0; m_owner = 0; m_grant_c = 0; m_ack_c = 0; m_wr = 0; m_age = 0;
    m_rd = 0; e_fd = 0; e_dd = 0; e_gd = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 1; k < 4; k++) begin
        if (act[k] == 0 && $urandom_range(0, 2) == 0) begin
          act[k]     = 1;
          r_addr[k]  = 8'($urandom_range(0, 31));
          r_we[k]    = (k == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          r_wdata[k] = (k == 2) ? 16'($urandom) : 16'h0;
        end
      end
      fetch_req = (act[1] != 0); fetch_addr = r_addr[1];
      data_req  = (act[2] != 0); data_addr  = r_addr[2];
      data_we   = r_we[2];       data_wdata = r_wdata[2];
      dbg_req   = (act[3] != 0); dbg_addr   = r_addr[3];

      // arbitration happens only when no access is outstanding
      if (m_busy == 0 && (act[1] + act[2] + act[3]) != 0) begin
        if (act[3] != 0 && m_age == SL) w = 3;
        else if (act[2] != 0)           w = 2;
        else if (act[1] != 0)           w = 1;
        else                            w = 3;
        if (act[3] != 0) m_age = (w == 3) ? 0 : ((m_age < SL) ? m_age + 1 : SL);
        m_busy = 1; m_owner = w; m_grant_c = c; m_ack_c = c + L + 2;
        m_wr = int'(r_we[w]);
        if (m_wr != 0) ref_mem[r_addr[w]] = r_wdata[w];
        else           m_rd = ref_mem[r_addr[w]];
      end

      own_exp = (m_busy != 0 && c > m_grant_c) ? m_owner : 0;
      en_exp  = (m_busy != 0 && c == m_grant_c + 1) ? 1 : 0;
      ack_exp = (m_busy != 0 && c == m_ack_c) ? 1 : 0;
      if (ack_exp != 0 && m_wr == 0) begin
        case (m_owner)
          1: e_fd = m_rd;
          2: e_dd = m_rd;
          default: e_gd = m_rd;
        endcase
      end

      chk("rnd_owner", owner, own_exp);
      chk("rnd_busy", busy, (own_exp != 0) ? 1 : 0);
      chk("rnd_mem_en", mem_en, en_exp);
      chk("rnd_mem_we", mem_we, (en_exp != 0 && m_wr != 0) ? 1 : 0);
      if (en_exp != 0) chk("rnd_mem_addr", mem_addr, r_addr[m_owner]);
      if (en_exp != 0 && m_wr != 0) chk("rnd_mem_wdata", mem_wdata, r_wdata[m_owner]);
      chk("rnd_fetch_ack", fetch_ack, (ack_exp != 0 && m_owner == 1) ? 1 : 0);
      chk("rnd_data_ack", data_ack, (ack_exp != 0 && m_owner == 2) ? 1 : 0);
      chk("rnd_dbg_ack", dbg_ack, (ack_exp != 0 && m_owner == 3) ? 1 : 0);
      chk("rnd_fetch_data", fetch_data, e_fd);
      chk("rnd_data_rdata", data_rdata, e_dd);
      chk("rnd_dbg_rdata", dbg_rdata, e_gd);

      if (ack_exp != 0) begin
        act[m_owner] = 0;
        m_busy = 0;
      end
      @(negedge clk);
    end

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
